mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS core.
- Sequences the shared datapath (immediate extender, ALU, register file, unified memory port) through FETCH/DECODE/EXEC/MEM/WB.
- Drives ext_op to the extender per opcode and runs a req/ready handshake with memory, guarded by a timeout watchdog.
- Sits between the instruction register and all datapath enables/selects.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before fault (>=2)
TO_W, 5, watchdog counter width (must hold MEM_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  address select: 0=PC, 1=ALU result
ir_we  out  1  load IR
mdr_we  out  1  load memory data register
pc_we  out  1  load PC
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
ext_op  out  2  extender mode, EXT_OP_SE/ZE/LS codes from common.v
alu_src_b  out  1  0=rt, 1=extended immediate
alu_op  out  3  0=ADD,1=SUB,2=AND,3=OR,4=SLT,5=PASS_B
rf_we  out  1  register file write
rf_dst  out  1  0=rt, 1=rd
wb_sel  out  1  0=ALU result, 1=MDR
fault  out  1  sticky fault flag
fault_code  out  2  01=illegal instr, 10=memory timeout

Behaviour:
- Reset (async, rst_n=0): state=FETCH, watchdog=0, fault=0, fault_code=0, all enables/req low, selects 0, ext_op=EXT_OP_SE. Deassertion mid-access drops mem_req immediately; no retry.
- Supported: R-type opcode 0 with funct ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, SLT 0x2A; ADDIU 0x09, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02. Anything else is illegal.
- ext_op: SE for ADDIU/LW/SW/BEQ, ZE for ANDI/ORI, LS for LUI. Registered in DECODE, held stable through EXEC/MEM/WB; R-type/J leave it at SE.
- FETCH: mem_req=1, iord=0, mem_we=0.
  - mem_ready=1 in the same cycle: ir_we=1, pc_we=1, pc_src=0, next DECODE.
- DECODE: latch ext_op/alu controls. Illegal -> FAULT, code 01. Else EXEC.
- EXEC:
  - R-type: alu_src_b=0, alu_op from funct -> WB.
  - I-arith: alu_src_b=1; ADDIU=ADD, ANDI=AND, ORI=OR, LUI=PASS_B -> WB.
  - LW/SW: ADD, alu_src_b=1 -> MEM.
  - BEQ: SUB, alu_src_b=0, pc_src=1, pc_we=zero -> FETCH.
  - J: pc_we=1, pc_src=2 -> FETCH.
- MEM: mem_req=1, iord=1, mem_we=1 for SW. On mem_ready: SW -> FETCH; LW asserts mdr_we=1 -> WB.
- WB: rf_we=1 for exactly one cycle. rf_dst=1 for R-type else 0; wb_sel=1 for LW -> FETCH.
- Handshake:
  - mem_req held high and address/we stable until mem_ready is sampled high.
  - Completion is on the edge where mem_req&mem_ready.
  - mem_req is low in the following cycle (no back-to-back request from the same state).
- Watchdog:
  - Clears when mem_req is low or on completion; otherwise increments each waiting cycle.
  - In the cycle where count==MEM_TIMEOUT-1 and mem_ready=0: next FAULT, code 10.
  - mem_ready=1 in that same cycle wins: normal completion, no fault.
- FAULT: all enables and mem_req low; fault=1, fault_code held; only reset exits.
- Enables are Mealy on mem_ready/zero; all other outputs are decoded from registered state.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: adds output ports instret[31:0] and cycles[31:0].
  - instret increments on the cycle an instruction retires: WB, SW completion in MEM, BEQ/J in EXEC.
  - cycles increments every clock except in FAULT.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports still present, tied to 0; no counter logic.

Test Plan:
- ORI opcode 0x0D, mem_ready=1 on first req -> ext_op=ZE from DECODE; rf_we pulses in WB; total 4 cycles FETCH..WB; rf_dst=0.
- LUI 0x0F then LW 0x23, ready delayed 3 cycles each access -> ext_op LS then SE; mem_req held 4 cycles per access; mdr_we once; wb_sel=1 in WB.
- BEQ with zero=1 vs zero=0 -> pc_we=1/pc_src=1 in EXEC vs pc_we=0; next state FETCH both cases.
- mem_ready never asserted, MEM_TIMEOUT=16 -> FAULT entered after 16 req cycles; fault=1, fault_code=10, mem_req low thereafter; mem_ready on the 16th cycle instead -> no fault.
- opcode 0x3F -> FAULT from DECODE, fault_code=01; rst_n pulse low mid-FAULT and mid-MEM -> outputs zero asynchronously; restart in FETCH.
- With MC_CTRL_PERF_EN: ADDU, SW, J sequence -> instret=3; cycles equals elapsed clocks.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB/FAULT) with memory watchdog.
// Define MC_CTRL_PERF_EN for live instret/cycles counters; otherwise both ports read zero.

module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  ext_op,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic        rf_dst,
  output logic        wb_sel,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  localparam logic [1:0] EXT_OP_SE = 2'd0;
  localparam logic [1:0] EXT_OP_ZE = 2'd1;
  localparam logic [1:0] EXT_OP_LS = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
  typedef enum logic [2:0] {K_RTYPE, K_IARITH, K_LW, K_SW, K_BEQ, K_J} kind_t;

  state_t          state_reg, state_next;
  kind_t           kind_reg, dec_kind;
  logic [2:0]      alu_op_reg, dec_alu;
  logic [1:0]      ext_op_reg, dec_ext;
  logic            dec_legal;
  logic [TO_W-1:0] wd_reg;
  logic [1:0]      fault_code_reg, fault_code_next;
  logic            req_state, timeout;

  // Instruction classification, only consumed while in DECODE.
  always_comb begin
    dec_legal = 1'b1;
    dec_kind  = K_RTYPE;
    dec_alu   = ALU_ADD;
    dec_ext   = EXT_OP_SE;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   dec_alu = ALU_ADD;
          6'h23:   dec_alu = ALU_SUB;
          6'h24:   dec_alu = ALU_AND;
          6'h25:   dec_alu = ALU_OR;
          6'h2A:   dec_alu = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h09: dec_kind = K_IARITH;
      6'h0C: begin dec_kind = K_IARITH; dec_alu = ALU_AND;  dec_ext = EXT_OP_ZE; end
      6'h0D: begin dec_kind = K_IARITH; dec_alu = ALU_OR;   dec_ext = EXT_OP_ZE; end
      6'h0F: begin dec_kind = K_IARITH; dec_alu = ALU_PASS; dec_ext = EXT_OP_LS; end
      6'h23: dec_kind = K_LW;
      6'h2B: dec_kind = K_SW;
      6'h04: begin dec_kind = K_BEQ; dec_alu = ALU_SUB; end
      6'h02: dec_kind = K_J;
      default: dec_legal = 1'b0;
    endcase
  end

  assign req_state = (state_reg == S_FETCH) || (state_reg == S_MEM);
  assign timeout   = req_state && !mem_ready && (wd_reg == WD_LAST);

  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    rf_dst    = 1'b0;
    wb_sel    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_next = S_EXEC;
        end else begin
          state_next      = S_FAULT;
          fault_code_next = 2'b01;
        end
      end
      S_EXEC: begin
        alu_op = alu_op_reg;
        case (kind_reg)
          K_RTYPE:      state_next = S_WB;
          K_IARITH:     begin alu_src_b = 1'b1; state_next = S_WB; end
          K_LW, K_SW:   begin alu_src_b = 1'b1; state_next = S_MEM; end
          K_BEQ:        begin pc_src = 2'd1; pc_we = zero; state_next = S_FETCH; end
          default:      begin pc_src = 2'd2; pc_we = 1'b1; state_next = S_FETCH; end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (kind_reg == K_SW);
        if (mem_ready) begin
          mdr_we     = (kind_reg == K_LW);
          state_next = (kind_reg == K_SW) ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = 2'b10;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_dst     = (kind_reg == K_RTYPE);
        wb_sel     = (kind_reg == K_LW);
        state_next = S_FETCH;
      end
      default: ;
    endcase
    // Reset state is FETCH, so mask the datapath strobes while rst_n is held low.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      rf_we     = 1'b0;
      rf_dst    = 1'b0;
      wb_sel    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_FETCH;
      kind_reg       <= K_RTYPE;
      alu_op_reg     <= ALU_ADD;
      ext_op_reg     <= EXT_OP_SE;
      wd_reg         <= '0;
      fault_code_reg <= 2'b00;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
      if (state_reg == S_DECODE) begin
        kind_reg   <= dec_kind;
        alu_op_reg <= dec_alu;
        ext_op_reg <= dec_ext;
      end
      if (!req_state || mem_ready) wd_reg <= '0;
      else                         wd_reg <= wd_reg + 1'b1;
    end
  end

  assign ext_op     = ext_op_reg;
  assign fault      = (state_reg == S_FAULT);
  assign fault_code = fault_code_reg;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret_reg, cycles_reg;
  logic        retire;

  assign retire = (state_reg == S_WB)
               || (state_reg == S_MEM && kind_reg == K_SW && mem_ready)
               || (state_reg == S_EXEC && (kind_reg == K_BEQ || kind_reg == K_J));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_reg <= '0;
      cycles_reg  <= '0;
    end else begin
      if (retire)               instret_reg <= instret_reg + 32'd1;
      if (state_reg != S_FAULT) cycles_reg  <= cycles_reg + 32'd1;
    end
  end

  assign instret = instret_reg;
  assign cycles  = cycles_reg;
`else
  assign instret = 32'd0;
  assign cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: builds the expected per-cycle output trace of each
// instruction from its class and memory latencies, then plays it against the DUT.

module tb_mc_ctrl;
  localparam int T = 16;
  localparam int KR = 0, KIA = 1, KLW = 2, KSW = 3, KBEQ = 4, KJ = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src, ext_op;
  logic        alu_src_b;
  logic [2:0]  alu_op;
  logic        rf_we, rf_dst, wb_sel, fault;
  logic [1:0]  fault_code;
  logic [31:0] instret, cycles;

  mc_ctrl #(.MEM_TIMEOUT(T), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .ext_op(ext_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .rf_dst(rf_dst),
    .wb_sel(wb_sel), .fault(fault), .fault_code(fault_code),
    .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req, we, iord, irwe, mdrwe, pcwe;
    logic [1:0] pcsrc;
    logic srcb;
    logic [2:0] aluop;
    logic rfwe, rfdst, wbsel, fault;
    logic [1:0] fcode;
  } out_t;

  typedef struct packed {
    logic rdy, zr, chk_ext;
    logic [1:0] ext;
    out_t o;
  } cyc_t;

  int tests = 0, fails = 0, steps = 0;

  function automatic out_t observe();
    out_t o;
    o.req = mem_req; o.we = mem_we; o.iord = iord; o.irwe = ir_we; o.mdrwe = mdr_we;
    o.pcwe = pc_we; o.pcsrc = pc_src; o.srcb = alu_src_b; o.aluop = alu_op;
    o.rfwe = rf_we; o.rfdst = rf_dst; o.wbsel = wb_sel; o.fault = fault; o.fcode = fault_code;
    return o;
  endfunction

  function automatic cyc_t idle();
    cyc_t c = '0;
    c.rdy = 1'($urandom);
    c.zr  = 1'($urandom);
    return c;
  endfunction

  // Instruction table: legality, ALU operation, operand B select, extender mode, class.
  task automatic classify(input logic [5:0] op, input logic [5:0] fn, output logic legal,
                          output logic [2:0] aop, output logic srcb, output logic [1:0] ex,
                          output int k);
    legal = 1'b1; aop = 3'd0; srcb = 1'b0; ex = 2'd0; k = KR;
    case (op)
      6'h00: case (fn)
               6'h21: aop = 3'd0;
               6'h23: aop = 3'd1;
               6'h24: aop = 3'd2;
               6'h25: aop = 3'd3;
               6'h2A: aop = 3'd4;
               default: legal = 1'b0;
             endcase
      6'h09: begin k = KIA; srcb = 1'b1; end
      6'h0C: begin k = KIA; srcb = 1'b1; aop = 3'd2; ex = 2'd1; end
      6'h0D: begin k = KIA; srcb = 1'b1; aop = 3'd3; ex = 2'd1; end
      6'h0F: begin k = KIA; srcb = 1'b1; aop = 3'd5; ex = 2'd2; end
      6'h23: begin k = KLW; srcb = 1'b1; end
      6'h2B: begin k = KSW; srcb = 1'b1; end
      6'h04: begin k = KBEQ; aop = 3'd1; end
      6'h02: k = KJ;
      default: legal = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    steps = 0;
  endtask

  // Runs one instruction from FETCH; df/dm are memory wait cycles (>=T means no answer).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int df,
                           input int dm, input logic z, input int abort, input string tag,
                           output logic faulted);
    cyc_t q[$];
    cyc_t c;
    logic legal, srcb;
    logic [2:0] aop;
    logic [1:0] ex;
    out_t got;
    int k, fc, played;
    fc = 0;
    played = 0;
    classify(op, fn, legal, aop, srcb, ex, k);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < df && i < T; i++) begin
      c = idle(); c.rdy = 1'b0; c.o.req = 1'b1; q.push_back(c);
    end
    if (df >= T) fc = 2;
    else begin
      c = idle(); c.rdy = 1'b1; c.o.req = 1'b1; c.o.irwe = 1'b1; c.o.pcwe = 1'b1;
      q.push_back(c);
      c = idle(); q.push_back(c);
      if (!legal) fc = 1;
      else begin
        c = idle(); c.zr = z; c.chk_ext = 1'b1; c.ext = ex; c.o.aluop = aop; c.o.srcb = srcb;
        if (k == KBEQ) begin c.o.pcsrc = 2'd1; c.o.pcwe = z; end
        if (k == KJ)   begin c.o.pcsrc = 2'd2; c.o.pcwe = 1'b1; end
        q.push_back(c);
        if (k == KLW || k == KSW) begin
          for (int i = 0; i < dm && i < T; i++) begin
            c = idle(); c.rdy = 1'b0; c.chk_ext = 1'b1; c.ext = ex;
            c.o.req = 1'b1; c.o.iord = 1'b1; c.o.we = (k == KSW); q.push_back(c);
          end
          if (dm >= T) fc = 2;
          else begin
            c = idle(); c.rdy = 1'b1; c.chk_ext = 1'b1; c.ext = ex;
            c.o.req = 1'b1; c.o.iord = 1'b1; c.o.we = (k == KSW); c.o.mdrwe = (k == KLW);
            q.push_back(c);
          end
        end
        if (fc == 0 && (k == KR || k == KIA || k == KLW)) begin
          c = idle(); c.chk_ext = 1'b1; c.ext = ex;
          c.o.rfwe = 1'b1; c.o.rfdst = (k == KR); c.o.wbsel = (k == KLW);
          q.push_back(c);
        end
      end
    end
    for (int i = 0; i < 3 && fc != 0; i++) begin
      c = idle(); c.o.fault = 1'b1; c.o.fcode = 2'(fc); q.push_back(c);
    end
    foreach (q[i]) begin
      if (abort >= 0 && i >= abort) break;
      mem_ready = q[i].rdy;
      zero      = q[i].zr;
      #1;
      got = observe();
      tests++;
      if (got !== q[i].o) begin
        fails++;
        $display("FAIL %s cyc%0d outputs got=%h required=%h", tag, i, got, q[i].o);
      end
      if (q[i].chk_ext) begin
        tests++;
        if (ext_op !== q[i].ext) begin
          fails++;
          $display("FAIL %s cyc%0d ext_op got=%0d required=%0d", tag, i, ext_op, q[i].ext);
        end
      end
      @(negedge clk);
      steps++;
      played++;
    end
    faulted = (fc != 0);
    $display("[TB] %s op=%h fn=%h df=%0d dm=%0d z=%0b cycles=%0d fault=%0d",
             tag, op, fn, df, dm, z, played, fc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (observe() !== '0 || ext_op !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h ext=%0d required=0", observe(), ext_op);
    end
    tests++;
    if (instret !== 32'd0 || cycles !== 32'd0) begin
      fails++;
      $display("FAIL reset_perf got=%0d/%0d required=0/0", instret, cycles);
    end
    do_reset();
  endtask

  task automatic test_ori();
    logic f;
    do_reset();
    run_instr(6'h0D, 6'h00, 0, 0, 1'b0, -1, "ori", f);
    tests++;
    if (steps !== 4) begin
      fails++;
      $display("FAIL ori_length got=%0d required=4", steps);
    end
  endtask

  task automatic test_lui_lw();
    logic f;
    run_instr(6'h0F, 6'h00, 3, 0, 1'b0, -1, "lui", f);
    run_instr(6'h23, 6'h00, 3, 3, 1'b0, -1, "lw", f);
  endtask

  task automatic test_beq();
    logic f;
    run_instr(6'h04, 6'h00, 1, 0, 1'b1, -1, "beq_taken", f);
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, -1, "beq_not_taken", f);
    run_instr(6'h00, 6'h25, 0, 0, 1'b0, -1, "or_after_beq", f);
  endtask

  task automatic test_timeout();
    logic f;
    do_reset();
    run_instr(6'h0D, 6'h00, T - 1, 0, 1'b0, -1, "fetch_ready_last", f);
    run_instr(6'h2B, 6'h00, 0, T - 1, 1'b0, -1, "sw_ready_last", f);
    run_instr(6'h23, 6'h00, 0, T + 4, 1'b0, -1, "lw_mem_timeout", f);
    do_reset();
    run_instr(6'h0D, 6'h00, T + 4, 0, 1'b0, -1, "fetch_timeout", f);
    do_reset();
  endtask

  task automatic test_illegal_async_reset();
    logic f;
    do_reset();
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, -1, "illegal_3f", f);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (observe() !== '0 || fault !== 1'b0 || fault_code !== 2'b00) begin
      fails++;
      $display("FAIL async_reset_fault got=%h required=0", observe());
    end
    do_reset();
    run_instr(6'h09, 6'h00, 0, 0, 1'b0, -1, "addiu_after_reset", f);
    run_instr(6'h23, 6'h00, 0, 10, 1'b0, 5, "lw_aborted", f);
    mem_ready = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b1 || iord !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_request got=%0b/%0b required=1/1", mem_req, iord);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (observe() !== '0) begin
      fails++;
      $display("FAIL async_reset_mem got=%h required=0", observe());
    end
    do_reset();
    run_instr(6'h0C, 6'h00, 1, 0, 1'b0, -1, "andi_after_reset", f);
  endtask

  task automatic test_random();
    logic [5:0] pool_op [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h0C,
                                 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] pool_fn [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] op, fn;
    logic f;
    int sel;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        sel = $urandom_range(12);
        op = pool_op[sel];
        fn = pool_fn[sel];
      end
      run_instr(op, fn, $urandom_range(4), $urandom_range(4), 1'($urandom), -1, "rand", f);
      if (f) do_reset();
    end
  endtask

  task automatic test_perf();
    logic f;
    logic [31:0] exp_i, exp_c;
    do_reset();
    run_instr(6'h00, 6'h21, 1, 0, 1'b0, -1, "perf_addu", f);
    run_instr(6'h2B, 6'h00, 0, 2, 1'b0, -1, "perf_sw", f);
    run_instr(6'h02, 6'h00, 2, 0, 1'b0, -1, "perf_j", f);
`ifdef MC_CTRL_PERF_EN
    exp_i = 32'd3;
    exp_c = 32'(steps);
`else
    exp_i = 32'd0;
    exp_c = 32'd0;
`endif
    tests++;
    if (instret !== exp_i) begin
      fails++;
      $display("FAIL perf_instret got=%0d required=%0d", instret, exp_i);
    end
    tests++;
    if (cycles !== exp_c) begin
      fails++;
      $display("FAIL perf_cycles got=%0d required=%0d", cycles, exp_c);
    end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_lui_lw();
    test_beq();
    test_timeout();
    test_illegal_async_reset();
    test_random();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit reached without completion");
    $fatal(1, "time limit");
  end

endmodule
